// File: rtl/msrr8_pkg.sv
// Shared definitions for the msrr8 multi-mode shift register.
// Holds operation codes, register width and the one-hot seed value.
package msrr8_pkg;

    localparam int WIDTH = 8;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_ROT  = 2'b11;

    localparam logic [WIDTH-1:0] SEED = 8'h01;

endpackage

// File: rtl/msrr8_cell.sv
// One bit of the msrr8 register: 4:1 neighbour mux plus seed/reset override.
// Ports: clk, Re (sync clear), inz (seed load), seed_bit, mode,
//   d_hold/d_shr/d_shl/d_rot (mux candidates), q (flop output).
module msrr8_cell
    import msrr8_pkg::*;
(
    input  logic       clk,
    input  logic       Re,
    input  logic       inz,
    input  logic       seed_bit,
    input  logic [1:0] mode,
    input  logic       d_hold,
    input  logic       d_shr,
    input  logic       d_shl,
    input  logic       d_rot,
    output logic       q
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = d_hold;
        unique case (mode)
            MODE_HOLD: q_d = d_hold;
            MODE_SHR:  q_d = d_shr;
            MODE_SHL:  q_d = d_shl;
            MODE_ROT:  q_d = d_rot;
            default:   q_d = d_hold;
        endcase
        if (inz) begin
            q_d = seed_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (Re) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/msrr8_ff.sv
// 8-bit multi-mode shift register: hold, shift right/left, rotate, seed load.
// Ports: clk, Re (sync active-high clear), inz (load 8'h01), sIn, mode, Q.
module msrr8_ff
    import msrr8_pkg::*;
(
    input  logic             clk,
    input  logic             Re,
    input  logic             inz,
    input  logic             sIn,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic shr_in;
        logic shl_in;
        logic rot_in;

        // Right moves data toward bit 0, so each bit takes its upper
        // neighbour; the ends take sIn or wrap around for rotate.
        if (i == WIDTH - 1) begin : g_msb
            assign shr_in = sIn;
            assign rot_in = q_w[0];
        end else begin : g_mid_r
            assign shr_in = q_w[i+1];
            assign rot_in = q_w[i+1];
        end

        if (i == 0) begin : g_lsb
            assign shl_in = sIn;
        end else begin : g_mid_l
            assign shl_in = q_w[i-1];
        end

        msrr8_cell u_cell (
            .clk      (clk),
            .Re       (Re),
            .inz      (inz),
            .seed_bit (SEED[i]),
            .mode     (mode),
            .d_hold   (q_w[i]),
            .d_shr    (shr_in),
            .d_shl    (shl_in),
            .d_rot    (rot_in),
            .q        (q_w[i])
        );
    end

    assign Q = q_w;

endmodule

// File: tb/tb_msrr8_ff.sv
// Scoreboard bench for msrr8_ff: driver pushes model results,
// monitor pops and compares one entry per clock edge.
module tb_msrr8_ff;

    typedef struct {
        logic [7:0] v;
        string      n;
    } exp_t;

    logic       clk = 1'b0;
    logic       Re = 1'b0;
    logic       inz = 1'b0;
    logic       sIn = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] Q;

    exp_t sb[$];
    int   model;
    int   passed = 0;
    int   total = 0;
    logic done = 1'b0;

    msrr8_ff dut (
        .clk  (clk),
        .Re   (Re),
        .inz  (inz),
        .sIn  (sIn),
        .mode (mode),
        .Q    (Q)
    );

    always #5 clk = ~clk;

    // Reference: whole-byte arithmetic on an integer.
    task automatic step(input logic re_i, input logic inz_i,
                        input logic s_i, input logic [1:0] m_i,
                        input string nm);
        @(negedge clk);
        Re   = re_i;
        inz  = inz_i;
        sIn  = s_i;
        mode = m_i;
        if (re_i) model = 0;
        else if (inz_i) model = 1;
        else begin
            case (m_i)
                2'd0: model = model;
                2'd1: model = (model >> 1) + (s_i ? 128 : 0);
                2'd2: model = ((model * 2) + (s_i ? 1 : 0)) % 256;
                default: model = (model >> 1) + ((model % 2) * 128);
            endcase
        end
        sb.push_back('{v: model[7:0], n: nm});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (Q !== e.v) begin
                    $display("FAIL %s: Q=%h expected %h at %0t",
                             e.n, Q, e.v, $time);
                end else begin
                    passed++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        if (!done) begin
            $display("FAIL timeout: run did not complete");
            $fatal(1, "timeout");
        end
    end

    initial begin : driver
        logic [7:0] pat;
        model = 0;
        // Reset, then hold
        step(1, 0, 1, 2'b01, "reset");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 2'b00, "hold_after_reset");
        // Shift right ones, then a zero
        for (int i = 0; i < 8; i++) step(0, 0, 1, 2'b01, "shr_ones");
        step(0, 0, 0, 2'b01, "shr_zero");
        // Shift left ones from zero, ninth edge, then zero
        step(1, 0, 0, 2'b00, "reset2");
        for (int i = 0; i < 9; i++) step(0, 0, 1, 2'b10, "shl_ones");
        step(0, 0, 0, 2'b10, "shl_zero");
        // Seed and full rotate period
        step(0, 1, 0, 2'b00, "seed");
        for (int i = 0; i < 8; i++) step(0, 0, 1, 2'b11, "rot_seed");
        // Build A5 by shift left, then rotate once
        pat = 8'hA5;
        for (int i = 7; i >= 0; i--) step(0, 0, pat[i], 2'b10, "load_a5");
        step(0, 0, 0, 2'b11, "rot_a5");
        // Zero stays zero under rotate
        step(1, 0, 0, 2'b00, "reset3");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 2'b11, "rot_zero");
        // Priority
        for (int i = 0; i < 8; i++) step(0, 0, 1, 2'b10, "fill_ff");
        step(1, 1, 1, 2'b10, "re_beats_inz");
        step(0, 1, 1, 2'b01, "inz_beats_mode");
        // Mid-shift reset, resume
        step(1, 0, 0, 2'b00, "reset4");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 2'b01, "shr4");
        step(1, 0, 1, 2'b01, "mid_reset");
        step(0, 0, 1, 2'b01, "resume_shr");
        // Hold with sIn toggling
        for (int i = 0; i < 5; i++) step(0, 0, i[0], 2'b00, "hold_toggle");
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(15) == 0), ($urandom_range(15) == 0),
                 1'($urandom_range(1)), 2'($urandom_range(3)), "random");
        end
        @(negedge clk);
        Re = 1'b0;
        inz = 1'b0;
        mode = 2'b00;
        repeat (4) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        done = 1'b1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
